// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider -- multi-cycle restoring divider, one quotient bit per clock.
//
// A start seen in IDLE captures the operands. A zero divisor finishes on the
// next cycle with quotient = all ones and remainder = dividend. Otherwise the
// block runs N restoring steps and then shows the result for one DONE cycle.
//
// Parameters:
//   N            operand / quotient / remainder width in bits (N >= 2)
// Ports:
//   clk          clock; all state updates on its rising edge
//   rst          synchronous, active-high reset
//   start        division request, sampled only in IDLE
//   dividend     dividend operand, captured on an accepted start
//   divisor      divisor operand, captured on an accepted start
//   busy         high in RUN and DONE; start is ignored while high
//   done         one-cycle pulse marking valid results
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when the captured divisor was zero
//
// Optional feature, selected by a compile-time macro:
//   SEQ_DIVIDER_SIGNED_EN  two's-complement operands. The core divides the
//                          magnitudes. The quotient truncates toward zero, and
//                          the remainder takes the dividend's sign.
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int           CW  = $clog2(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [N:0]    prem;      // partial remainder, one bit wider than divisor
   logic [N-1:0]  dreg;      // dividend bits shift out of the top, quotient bits shift in at the bottom
   logic [N-1:0]  dvsr;

   logic          zero_div;
   logic          last_step;
   logic [N:0]    prem_sh;
   logic [N+1:0]  diff;
   logic          qbit;
   logic [N-1:0]  q_raw, r_raw;
   logic [N-1:0]  op_a, op_b;
   logic [N-1:0]  q_fin, r_fin;

   assign zero_div  = (divisor == '0);
   assign last_step = (cnt == CW'(N - 1));

   // One restoring step: shift, then trial-subtract. The extra top bit of
   // diff is the borrow, so a clear borrow means the difference is kept.
   assign prem_sh = {prem[N-1:0], dreg[N-1]};
   assign diff    = {1'b0, prem_sh} - {2'b00, dvsr};
   assign qbit    = ~diff[N+1];
   assign q_raw   = {dreg[N-2:0], qbit};
   assign r_raw   = qbit ? diff[N-1:0] : prem_sh[N-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q, neg_r;

   // Magnitudes of the operands. The most negative value maps to 2^(N-1).
   // That still fits in N unsigned bits.
   assign op_a  = dividend[N-1] ? (~dividend + ONE) : dividend;
   assign op_b  = divisor[N-1]  ? (~divisor  + ONE) : divisor;
   assign q_fin = neg_q ? (~q_raw + ONE) : q_raw;
   assign r_fin = neg_r ? (~r_raw + ONE) : r_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && start && !zero_div) begin
         neg_q <= dividend[N-1] ^ divisor[N-1];
         neg_r <= dividend[N-1];
      end
   end
`else
   assign op_a  = dividend;
   assign op_b  = divisor;
   assign q_fin = q_raw;
   assign r_fin = r_raw;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = zero_div ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         prem        <= '0;
         dreg        <= '0;
         dvsr        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (zero_div) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     cnt         <= '0;
                     prem        <= '0;
                     dreg        <= op_a;
                     dvsr        <= op_b;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            RUN: begin
               cnt  <= cnt + CW'(1);
               prem <= qbit ? diff[N:0] : prem_sh;
               dreg <= q_raw;
               if (last_step) begin
                  quotient  <= q_fin;
                  remainder <= r_fin;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider -- directed, self-checking bench for seq_divider (N = 8).
// Expected results are computed by hand. Latency is counted from the cycle
// where start is presented to the done cycle: N+1 for a normal divide and 1
// for a divide-by-zero.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, with a bound. Returns the number of edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez,
                         input int elat);
    int lat;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check({tag, " busy_after_accept"}, busy, 1);
    wait_done(lat);
    check({tag, " latency"}, lat + 1, elat);
    check({tag, " done"}, done, 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    tick();
    check({tag, " done_pulse_one_cycle"}, done, 0);
    check({tag, " idle_after_done"}, busy, 0);
    check({tag, " quotient_held"}, quotient, eq);
    check({tag, " remainder_held"}, remainder, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_seen;
    rst      = 1'b1;
    start    = 1'b1;      // reset must override start
    dividend = 8'd100;
    divisor  = 8'd7;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // The first start after reset is accepted normally.
    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9);
    run_div("d7_8", 8'd7, 8'd8, 8'd0, 8'd7, 1'b0, 9);

    // Divide by zero, then a valid divisor clears the flag.
    run_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("dbz cleared_on_accept", div_by_zero, 0);
    wait_done(lat);
    check("dbz_then_valid quotient", quotient, 14);
    check("dbz_then_valid remainder", remainder, 2);
    tick();

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run_div("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
    run_div("s_m7_m2", 8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 9);
    run_div("s_m5_0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1);
`else
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_div("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    run_div("d254_16", 8'd254, 8'd16, 8'd15, 8'd14, 1'b0, 9);
`endif

    // start held high while the operands change during RUN.
    dividend = 8'd120;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();
    dividend = 8'd13;
    divisor  = 8'd3;
    wait_done(lat);
    check("held latency", lat + 1, 9);
    check("held quotient", quotient, 13);
    check("held remainder", remainder, 3);
    tick();
    check("held start_ignored_in_done", busy, 0);
    tick();
    check("held reaccept_in_idle", busy, 1);
    start = 1'b0;
    wait_done(lat);
    check("held second latency", lat, 8);
    check("held second quotient", quotient, 4);
    check("held second remainder", remainder, 1);
    tick();

    // Reset pulsed on cycle 4 of RUN aborts the operation.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("abort no_done_pulse", done_seen, 0);
    run_div("after_abort", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
